// File: rtl/adder_pipe.sv
// adder_pipe: two-stage add/subtract pipeline with valid/ready handshakes.
// Stage 1 registers the raw WIDTH+1-bit sum a + (sub ? ~b : b) + cin.
// Stage 2 applies the mode-specific correction and registers the result.
// Modes: 0 unsigned, 1 ones-complement, 2 twos-complement,
//        3 saturating twos-complement (only when ADDER_PIPE_SAT_EN is defined;
//        otherwise the mode is flagged with err_o and the result is forced to 0).
module adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       f_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam logic [1:0] MODE_UNS  = 2'd0;
  localparam logic [1:0] MODE_ONES = 2'd1;
  localparam logic [1:0] MODE_TWOS = 2'd2;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage 1 state
  logic             r_s1_valid;
  logic [1:0]       r_s1_f;
  logic             r_s1_sub;
  logic [WIDTH:0]   r_s1_raw;
  logic             r_s1_sa;   // sign of a
  logic             r_s1_sb;   // sign of the effective (possibly inverted) b

  // Stage 2 state
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic             r_s2_carry;
  logic             r_s2_ovf;
  logic             r_s2_err;

  // Combinational helpers
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_raw;
  logic             w_s2_adv;
  logic             w_same_sign;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;

  assign w_b_eff = sub_i ? ~b_i : b_i;
  // Ones-complement subtraction relies on the end-around carry instead of cin.
  assign w_cin   = sub_i && (f_i != MODE_ONES);
  assign w_raw   = {1'b0, a_i} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

  // A stage advances when it is empty or the stage after it advances.
  assign w_s2_adv   = !r_s2_valid || out_ready_i;
  assign in_ready_o = !r_s1_valid || w_s2_adv;

  // Stage 1: capture operands' raw sum on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready_o) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1_f   <= f_i;
        r_s1_sub <= sub_i;
        r_s1_raw <= w_raw;
        r_s1_sa  <= a_i[WIDTH-1];
        r_s1_sb  <= w_b_eff[WIDTH-1];
      end
    end
  end

  assign w_same_sign = (r_s1_sa == r_s1_sb);

  // Mode correction of the raw stage-1 sum.
  always_comb begin
    w_y     = r_s1_raw[WIDTH-1:0];
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (r_s1_f)
      MODE_UNS: begin
        w_carry = r_s1_sub ? ~r_s1_raw[WIDTH] : r_s1_raw[WIDTH];
      end
      MODE_ONES: begin
        // End-around carry; negative zero (all ones) is left as is.
        w_y   = r_s1_raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, r_s1_raw[WIDTH]};
        w_ovf = w_same_sign && (w_y[WIDTH-1] != r_s1_sa);
      end
      MODE_TWOS: begin
        w_ovf = w_same_sign && (r_s1_raw[WIDTH-1] != r_s1_sa);
      end
      default: begin
`ifdef ADDER_PIPE_SAT_EN
        w_ovf = w_same_sign && (r_s1_raw[WIDTH-1] != r_s1_sa);
        if (w_ovf) begin
          w_y = r_s1_sa ? SAT_MIN : SAT_MAX;
        end
`else
        w_y   = '0;
        w_err = 1'b1;
`endif
      end
    endcase
  end

  // Stage 2: register corrected result; holds while output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_carry <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_y     <= w_y;
        r_s2_carry <= w_carry;
        r_s2_ovf   <= w_ovf;
        r_s2_err   <= w_err;
      end
    end
  end

  assign out_valid_o = r_s2_valid;
  assign y_o         = r_s2_y;
  assign carry_o     = r_s2_carry;
  assign ovf_o       = r_s2_ovf;
  assign err_o       = r_s2_err;

endmodule
